operand_entry: RTL and testbench
================================

OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, is the number of consecutive stable cycles a button needs before it is accepted.
REQ-002 Parameter DIGIT_W, default 4, is the width of the operand outputs a and b.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert and active-low (decided; not configurable).
REQ-005 num  in  9  one-hot digit switches, asynchronous; all-zero = digit 0, bit k = digit k+1.
REQ-006 loada, loadb  in  1 each  raw push-buttons that load operand A or B from num.
REQ-007 mode  in  4  one-hot operation switches: 0001 add, 0010 mul, 0100 sub, 1000 div.
REQ-008 go  in  1  raw push-button that requests an issue to the downstream functions stage.
REQ-009 clr  in  1  raw push-button that clears all entry state.
REQ-010 a, b  out  DIGIT_W each  registered operands, range 0..9.
REQ-011 op_mode  out  4  registered one-hot operation, captured at go.
REQ-012 valid  out  1, ready  in  1  issue handshake; the transfer occurs in a cycle where valid && ready.
REQ-013 err  out  1  sticky entry-error flag.

Function
REQ-014 num and mode shall pass through 2-flop synchronizers; every button shall pass through button_conditioner, which outputs a 1-cycle accept pulse.
REQ-015 Without debounce, a, b, op_mode and valid shall change exactly 3 rising clk edges after a raw button rising edge (2 sync edges plus 1 edge-detect edge).
REQ-016 Digit decode: num all-zero -> 0; exactly one bit k set -> k+1; two or more bits set -> invalid, so the target register is unchanged and err is set to 1.
REQ-017 FSM states are ENTRY and ISSUE; the reset state is ENTRY.
REQ-018 ENTRY behaviour:
- a loada accept with a valid digit loads a and sets a_vld.
- a loadb accept with a valid digit loads b and sets b_vld.
- simultaneous loada and loadb accepts load the same digit into both.
REQ-019 ENTRY go accept with a_vld, b_vld, and mode exactly one-hot: capture op_mode, clear err, set valid=1, move to ISSUE.
REQ-020 ENTRY go accept with a missing operand, mode not one-hot, or mode=1000 with b=0: set err=1, keep valid=0, stay in ENTRY.
REQ-021 ISSUE behaviour:
- valid=1, and a, b and op_mode are held stable.
- loada, loadb and go accepts are ignored and discarded, not queued.
REQ-022 ISSUE with valid && ready: the next cycle has valid=0 and the state is ENTRY; a, b, a_vld and b_vld are retained for re-issue.
REQ-023 ready with valid=0 shall have no effect.
REQ-024 A clr accept in any state, on the next edge:
- a=0, b=0, op_mode=0, valid=0, err=0;
- a_vld and b_vld cleared;
- state ENTRY.
REQ-025 clr has priority over go, load and handshake events in the same cycle.
REQ-026 err shall remain 1 until the next successful go or a clr.

Reset
REQ-027 rst_n low shall immediately force:
- a=0, b=0, op_mode=0, valid=0, err=0;
- a_vld=0, b_vld=0, state ENTRY;
- all synchronizer, debounce and edge-detect flops to 0.
REQ-028 Reset asserted during ISSUE shall drop valid without a handshake.
REQ-029 After rst_n rises, a button already held high shall not generate an accept until it is released and pressed again.

Configuration
REQ-030 With macro OPERAND_ENTRY_DEBOUNCE_EN defined:
- each button_conditioner has a counter that requires DEBOUNCE_CYCLES consecutive identical synchronized samples before its stable level changes;
- the accept pulse is the rising edge of that stable level;
- latency is 3+DEBOUNCE_CYCLES edges.
REQ-031 Without OPERAND_ENTRY_DEBOUNCE_EN, button_conditioner shall be synchronizer plus edge detect only, with no counter logic and latency as in REQ-015.

Structure
REQ-032 Shared package calc_pkg shall hold:
- the state enum (ENTRY, ISSUE);
- mode constants MODE_ADD, MODE_MUL, MODE_SUB, MODE_DIV;
- DIGIT_W default;
- the one-hot digit decode function.
REQ-033 One sub-module, button_conditioner (sync, optional debounce, rising-edge pulse), shall be instantiated four times: loada, loadb, go, clr.

Verification (debounce enabled, DEBOUNCE_CYCLES=4)
REQ-034 Issue with backpressure:
- num=000000100, press loada -> a=3; num=100000000, press loadb -> b=9;
- mode=0010, press go -> valid=1, op_mode=0010;
- ready=0 for 5 cycles -> outputs stable; ready=1 -> valid=0 on the next cycle.
REQ-035 num=000000011, press loada -> a unchanged, err=1; then a valid go -> err=0.
REQ-036 b=0, mode=1000, press go -> valid stays 0, err=1; mode=0110 -> same result.
REQ-037 Bounce on loada (high 2, low 1, high 2 cycles) -> no load; loada held high 4+ cycles -> exactly one load.
REQ-038 rst_n low during ISSUE -> valid=0 and a=b=0 before the next clk edge.
REQ-039 clr and go accepted in the same cycle -> state ENTRY, valid=0, a=b=0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types, constants and digit decode for the operand entry front end.
package calc_pkg;

  typedef enum logic {ENTRY = 1'b0, ISSUE = 1'b1} state_t;

  localparam logic [3:0] MODE_ADD = 4'b0001;
  localparam logic [3:0] MODE_MUL = 4'b0010;
  localparam logic [3:0] MODE_SUB = 4'b0100;
  localparam logic [3:0] MODE_DIV = 4'b1000;

  localparam int DIGIT_W_DEF = 4;

  typedef struct packed {
    logic       ok;
    logic [3:0] val;
  } digit_t;

  // All-zero is digit 0, a single bit k is digit k+1, anything else is rejected.
  function automatic digit_t decode_digit(input logic [8:0] n);
    digit_t d;
    d.ok  = 1'b1;
    d.val = 4'd0;
    if ((n & (n - 9'd1)) != 9'd0) begin
      d.ok = 1'b0;
    end else begin
      for (int k = 0; k < 9; k++) begin
        if (n[k]) d.val = 4'(k + 1);
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Raw push-button to single-cycle accept pulse: 2-flop sync, optional debounce, rising edge.
// Debounce counter is built only when OPERAND_ENTRY_DEBOUNCE_EN is defined.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic accept
);

  logic s1, s2;
  logic w1, w2;
  logic armed;

  // armed only goes high once a genuine low level has come through the
  // synchronizer, so a button held across reset cannot produce an accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      w1    <= 1'b0;
      w2    <= 1'b0;
      armed <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      w1    <= 1'b1;
      w2    <= w1;
      armed <= armed | (w2 & ~s2);
    end
  end

`ifdef OPERAND_ENTRY_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          stable, stable_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      stable_q <= stable;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt    <= '0;
        stable <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign accept = armed & stable & ~stable_q;
`else
  logic s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s2_q <= 1'b0;
    else        s2_q <= s2;
  end

  assign accept = armed & s2 & ~s2_q;
`endif

endmodule

// File: rtl/operand_entry.sv
// Operand/operation entry stage with a valid/ready issue port to the functions stage.
// Button debounce is enabled by defining OPERAND_ENTRY_DEBOUNCE_EN.
module operand_entry
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DIGIT_W         = DIGIT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [8:0]         num,
  input  logic               loada,
  input  logic               loadb,
  input  logic [3:0]         mode,
  input  logic               go,
  input  logic               clr,
  output logic [DIGIT_W-1:0] a,
  output logic [DIGIT_W-1:0] b,
  output logic [3:0]         op_mode,
  output logic               valid,
  input  logic               ready,
  output logic               err
);

  logic [8:0] num_s1, num_s;
  logic [3:0] mode_s1, mode_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_s1  <= '0;
      num_s   <= '0;
      mode_s1 <= '0;
      mode_s  <= '0;
    end else begin
      num_s1  <= num;
      num_s   <= num_s1;
      mode_s1 <= mode;
      mode_s  <= mode_s1;
    end
  end

  logic loada_acc, loadb_acc, go_acc, clr_acc;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_loada (
    .clk(clk), .rst_n(rst_n), .raw(loada), .accept(loada_acc));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_loadb (
    .clk(clk), .rst_n(rst_n), .raw(loadb), .accept(loadb_acc));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_go (
    .clk(clk), .rst_n(rst_n), .raw(go), .accept(go_acc));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
    .clk(clk), .rst_n(rst_n), .raw(clr), .accept(clr_acc));

  state_t state, state_next;
  digit_t dig;
  logic   a_vld, b_vld;
  logic   go_ok;

  assign dig   = decode_digit(num_s);
  assign go_ok = a_vld && b_vld && $onehot(mode_s) &&
                 !((mode_s == MODE_DIV) && (b == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ENTRY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clr_acc) begin
      state_next = ENTRY;
    end else begin
      unique case (state)
        ENTRY:   if (go_acc && go_ok) state_next = ISSUE;
        ISSUE:   if (ready)           state_next = ENTRY;
        default: state_next = ENTRY;
      endcase
    end
  end

  assign valid = (state == ISSUE);

  logic [DIGIT_W-1:0] a_n, b_n;
  logic [3:0]         op_n;
  logic               a_vld_n, b_vld_n, err_n;

  // Go is judged on the registered operands; a load in the same cycle only
  // affects the next issue, and a bad digit still flags err.
  always_comb begin
    a_n     = a;
    b_n     = b;
    a_vld_n = a_vld;
    b_vld_n = b_vld;
    op_n    = op_mode;
    err_n   = err;
    if (clr_acc) begin
      a_n     = '0;
      b_n     = '0;
      a_vld_n = 1'b0;
      b_vld_n = 1'b0;
      op_n    = '0;
      err_n   = 1'b0;
    end else if (state == ENTRY) begin
      if (go_acc) begin
        if (go_ok) begin
          op_n  = mode_s;
          err_n = 1'b0;
        end else begin
          err_n = 1'b1;
        end
      end
      if (loada_acc || loadb_acc) begin
        if (dig.ok) begin
          if (loada_acc) begin
            a_n     = DIGIT_W'(dig.val);
            a_vld_n = 1'b1;
          end
          if (loadb_acc) begin
            b_n     = DIGIT_W'(dig.val);
            b_vld_n = 1'b1;
          end
        end else begin
          err_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a       <= '0;
      b       <= '0;
      a_vld   <= 1'b0;
      b_vld   <= 1'b0;
      op_mode <= '0;
      err     <= 1'b0;
    end else begin
      a       <= a_n;
      b       <= b_n;
      a_vld   <= a_vld_n;
      b_vld   <= b_vld_n;
      op_mode <= op_n;
      err     <= err_n;
    end
  end

endmodule

// File: tb/tb_operand_entry.sv
// Randomized bench for operand_entry against a behavioural entry model, with pinned scenarios.
module tb_operand_entry;

  localparam int DEB = 4;
  localparam int DW  = 4;
`ifdef OPERAND_ENTRY_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
  localparam int LAT    = 3 + DEB;
`else
  localparam bit DEB_EN = 1'b0;
  localparam int LAT    = 3;
`endif
  localparam int HOLD   = DEB_EN ? DEB + 2 : 2;
  localparam int SETTLE = DEB_EN ? DEB + 6 : 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [8:0]    num = '0;
  logic          loada = 1'b0, loadb = 1'b0, go = 1'b0, clr = 1'b0;
  logic [3:0]    mode = 4'b0001;
  logic          ready = 1'b0;
  logic [DW-1:0] a, b;
  logic [3:0]    op_mode;
  logic          valid, err;

  operand_entry #(.DEBOUNCE_CYCLES(DEB), .DIGIT_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .num(num), .loada(loada), .loadb(loadb),
    .mode(mode), .go(go), .clr(clr), .a(a), .b(b), .op_mode(op_mode),
    .valid(valid), .ready(ready), .err(err));

  always #5 clk = ~clk;

  int   m_a, m_b, m_op;
  bit   m_avld, m_bvld, m_valid, m_err;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   cmp_en = 1'b0;

  task automatic check_output(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check_output("cyc_a", int'(a), m_a);
      check_output("cyc_b", int'(b), m_b);
      check_output("cyc_op_mode", int'(op_mode), m_op);
      check_output("cyc_valid", int'(valid), int'(m_valid));
      check_output("cyc_err", int'(err), int'(m_err));
    end
  end

  task automatic model_clear();
    m_a = 0; m_b = 0; m_op = 0;
    m_avld = 0; m_bvld = 0; m_valid = 0; m_err = 0;
  endtask

  // Count the set switches: none is 0, one at position k is k+1, more is invalid.
  task automatic model_decode(input logic [8:0] n, output bit ok, output int v);
    int cnt = 0;
    v = 0;
    for (int k = 0; k < 9; k++) if (n[k]) begin cnt++; v = k + 1; end
    ok = (cnt <= 1);
  endtask

  task automatic model_event(input bit la, input bit lb, input bit g, input bit c);
    bit ok;
    int v;
    if (c) begin model_clear(); return; end
    if (m_valid) return;
    if (g) begin
      if (m_avld && m_bvld && $countones(mode) == 1 && !(mode == 4'b1000 && m_b == 0)) begin
        m_op = int'(mode); m_err = 0; m_valid = 1;
      end else m_err = 1;
    end
    if (la || lb) begin
      model_decode(num, ok, v);
      if (ok) begin
        if (la) begin m_a = v; m_avld = 1; end
        if (lb) begin m_b = v; m_bvld = 1; end
      end else m_err = 1;
    end
  endtask

  // One clean press of the chosen buttons; the model takes effect on the edge the DUT should.
  task automatic apply_stimulus(input bit la, input bit lb, input bit g, input bit c);
    for (int cyc = 1; cyc <= HOLD + SETTLE; cyc++) begin
      @(negedge clk);
      loada = la && cyc <= HOLD;
      loadb = lb && cyc <= HOLD;
      go    = g  && cyc <= HOLD;
      clr   = c  && cyc <= HOLD;
      ready = m_valid ? 1'b0 : 1'($urandom_range(0, 1));
      @(posedge clk);
      if (cyc == LAT) model_event(la, lb, g, c);
    end
    @(negedge clk);
    {loada, loadb, go, clr} = '0;
    if (m_valid) ready = 1'b0;
  endtask

  task automatic handshake(input int wait_n);
    for (int i = 0; i < wait_n; i++) begin
      @(negedge clk); ready = 1'b0;
    end
    @(negedge clk); ready = 1'b1;
    @(posedge clk); m_valid = 0;
    @(negedge clk); ready = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0; ready = 1'b0;
    model_clear();
    #1;
    check_output("rst_valid", int'(valid), 0);
    check_output("rst_a", int'(a), 0);
    check_output("rst_b", int'(b), 0);
    check_output("rst_err", int'(err), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  function automatic logic [8:0] rand_num();
    int r = $urandom_range(0, 5);
    if (r == 0) return '0;
    if (r <= 3) return 9'(1 << $urandom_range(0, 8));
    return 9'($urandom_range(0, 511));
  endfunction

  logic [7:0] bounce = 8'b0001_1011;

  initial begin
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    cmp_en = 1'b1;
    check_output("reset_op_mode", int'(op_mode), 0);
    check_output("reset_valid", int'(valid), 0);

    // issue with backpressure
    num = 9'b000000100; apply_stimulus(1, 0, 0, 0);
    check_output("load_a_3", int'(a), 3);
    num = 9'b100000000; apply_stimulus(0, 1, 0, 0);
    check_output("load_b_9", int'(b), 9);
    mode = 4'b0010; apply_stimulus(0, 0, 1, 0);
    check_output("go_valid", int'(valid), 1);
    check_output("go_op_mode", int'(op_mode), 2);
    handshake(5);
    check_output("hs_valid_low", int'(valid), 0);
    check_output("hs_a_kept", int'(a), 3);

    // invalid digit sets err, next good go clears it
    num = 9'b000000011; apply_stimulus(1, 0, 0, 0);
    check_output("bad_digit_a", int'(a), 3);
    check_output("bad_digit_err", int'(err), 1);
    apply_stimulus(0, 0, 1, 0);
    check_output("rego_err", int'(err), 0);
    check_output("rego_valid", int'(valid), 1);
    handshake(0);

    // divide by zero and non-one-hot mode
    num = '0; apply_stimulus(0, 1, 0, 0);
    mode = 4'b1000; apply_stimulus(0, 0, 1, 0);
    check_output("div0_valid", int'(valid), 0);
    check_output("div0_err", int'(err), 1);
    mode = 4'b0110; apply_stimulus(0, 0, 1, 0);
    check_output("mode2hot_valid", int'(valid), 0);
    check_output("mode2hot_err", int'(err), 1);

    // bounce on loada: filtered only when debounce is built in
    num = 9'b000010000;
    for (int cyc = 1; cyc <= 8 + SETTLE; cyc++) begin
      @(negedge clk);
      loada = (cyc <= 8) ? bounce[cyc-1] : 1'b0;
      @(posedge clk);
      if (!DEB_EN && cyc - LAT >= 0 && cyc - LAT < 8 && bounce[cyc-LAT] &&
          (cyc - LAT == 0 || !bounce[cyc-LAT-1]))
        model_event(1, 0, 0, 0);
    end
    check_output("bounce_a", int'(a), DEB_EN ? 3 : 5);
    num = 9'b000100000; apply_stimulus(1, 0, 0, 0);
    check_output("held_a", int'(a), 6);

    // loads in ISSUE are discarded
    num = 9'b000000001; apply_stimulus(0, 1, 0, 0);
    mode = 4'b0001; apply_stimulus(0, 0, 1, 0);
    num = 9'b001000000; apply_stimulus(1, 0, 0, 0);
    check_output("issue_hold_a", int'(a), 6);
    handshake(2);

    // reset in ISSUE drops valid at once
    apply_stimulus(0, 0, 1, 0);
    check_output("pre_rst_valid", int'(valid), 1);
    do_reset();

    // button held through reset must be released first
    @(negedge clk); loada = 1'b1; num = 9'b000000010;
    do_reset();
    repeat (HOLD + SETTLE) @(negedge clk);
    check_output("held_rst_a", int'(a), 0);
    loada = 1'b0;
    repeat (SETTLE + 4) @(negedge clk);
    apply_stimulus(1, 0, 0, 0);
    check_output("after_rel_a", int'(a), 2);

    // clr and go together
    num = 9'b000001000; apply_stimulus(0, 1, 0, 0);
    mode = 4'b0100; apply_stimulus(0, 0, 1, 1);
    check_output("clrgo_valid", int'(valid), 0);
    check_output("clrgo_a", int'(a), 0);
    check_output("clrgo_b", int'(b), 0);

    // randomized sequences
    for (int it = 0; it < 60; it++) begin
      int act = $urandom_range(0, 9);
      num  = rand_num();
      mode = ($urandom_range(0, 3) != 0) ? 4'(1 << $urandom_range(0, 3))
                                        : 4'($urandom_range(0, 15));
      @(negedge clk);
      if (m_valid && act >= 7) handshake($urandom_range(0, 3));
      else if (act <= 1) apply_stimulus(1, 0, 0, 0);
      else if (act <= 3) apply_stimulus(0, 1, 0, 0);
      else if (act == 4) apply_stimulus(1, 1, 0, 0);
      else if (act <= 7) apply_stimulus(0, 0, 1, 0);
      else if (act == 8) apply_stimulus(0, 0, 0, 1);
      else apply_stimulus(0, 0, 1, 0);
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
